// File: rtl/nios_mul_share_arbiter.sv
// Round-robin sharing of one pipelined 32x32 -> low-32 multiplier cell between NUM_REQ requesters.
// Define MUL_SHARE_PERF_CNT_EN to add saturating issue/stall performance counters.
module nios_mul_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_src1,
    input  logic [32*NUM_REQ-1:0]  req_src2,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [32*NUM_REQ-1:0]  rsp_result,
    output logic [31:0]            mul_src1,
    output logic [31:0]            mul_src2,
    input  logic [31:0]            mul_result,
    output logic                   busy
`ifdef MUL_SHARE_PERF_CNT_EN
    ,
    output logic [31:0]            perf_issue_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);

    logic [NUM_REQ-1:0]        pending;
    logic [NUM_REQ-1:0]        eligible;
    logic [NUM_REQ-1:0]        rsp_fire;
    logic [7:0]                elig_pad;
    logic [2:0]                rr_ptr;
    logic [2:0]                win_id;
    logic [2:0]                next_ptr;
    logic                      grant_any;
    logic [LATENCY-1:0]        tag_vld;
    logic [LATENCY-1:0][2:0]   tag_id;
    logic                      cap_vld;
    logic [2:0]                cap_id;

    assign eligible = req_valid & ~pending;
    assign rsp_fire = rsp_valid & rsp_ready;
    assign cap_vld  = tag_vld[LATENCY-1];
    assign cap_id   = tag_id[LATENCY-1];
    assign busy     = |tag_vld;

    // Padded to 8 so the rotating search can index with a 3-bit id for any NUM_REQ.
    always_comb begin
        elig_pad = '0;
        elig_pad[NUM_REQ-1:0] = eligible;
    end

    always_comb begin
        logic [3:0] idx;
        idx       = '0;
        grant_any = 1'b0;
        win_id    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + 4'(k);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end
            if (!grant_any && elig_pad[idx[2:0]]) begin
                grant_any = 1'b1;
                win_id    = idx[2:0];
            end
        end
        if (reset) begin
            grant_any = 1'b0;
            win_id    = '0;
        end
    end

    always_comb begin
        req_ready = '0;
        mul_src1  = '0;
        mul_src2  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_any && win_id == 3'(i)) begin
                req_ready[i] = 1'b1;
                mul_src1     = req_src1[i*32 +: 32];
                mul_src2     = req_src2[i*32 +: 32];
            end
        end
    end

    assign next_ptr = (win_id == 3'(NUM_REQ - 1)) ? 3'd0 : win_id + 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            pending    <= '0;
            tag_vld    <= '0;
            tag_id     <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
        end else begin
            if (grant_any) begin
                rr_ptr <= next_ptr;
            end
            tag_vld[0] <= grant_any;
            tag_id[0]  <= win_id;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
            // Grant and response handshake never coincide for one requester: pending blocks the grant.
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    pending[i] <= 1'b1;
                end else if (rsp_fire[i]) begin
                    pending[i] <= 1'b0;
                end
                if (cap_vld && cap_id == 3'(i)) begin
                    rsp_valid[i]            <= 1'b1;
                    rsp_result[i*32 +: 32]  <= mul_result;
                end else if (rsp_fire[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef MUL_SHARE_PERF_CNT_EN
    logic stall_cycle;

    assign stall_cycle = |(eligible & ~req_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (grant_any && perf_issue_cnt != '1) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (stall_cycle && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nios_mul_share_arbiter.sv
// Bench for nios_mul_share_arbiter: DUT A (2 requesters, latency 1) and DUT B (3 requesters, latency 3),
// each driving a behavioural multiplier cell; responses are checked by a scoreboard on rsp_valid rise.
module tb_nios_mul_share_arbiter;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] val;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic [31:0] cyc = '0;
    int          checks = 0;
    int          failures = 0;
    exp_t        qa[$];
    exp_t        qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // DUT A
    logic        a_reset;
    logic [1:0]  a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [63:0] a_src1, a_src2, a_rsp_result;
    logic [31:0] a_mul_src1, a_mul_src2, a_mul_result;
    logic        a_busy;
    // DUT B
    logic        b_reset;
    logic [2:0]  b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [95:0] b_src1, b_src2, b_rsp_result;
    logic [31:0] b_mul_src1, b_mul_src2, b_mul_result, b_p1, b_p2;
    logic        b_busy;
`ifdef MUL_SHARE_PERF_CNT_EN
    logic [31:0] a_perf_issue, a_perf_stall, b_perf_issue, b_perf_stall;
`endif

    nios_mul_share_arbiter #(.NUM_REQ(2), .LATENCY(1)) u_a (
        .clk(clk), .reset(a_reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_src1(a_src1), .req_src2(a_src2),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_result(a_rsp_result),
        .mul_src1(a_mul_src1), .mul_src2(a_mul_src2), .mul_result(a_mul_result),
        .busy(a_busy)
`ifdef MUL_SHARE_PERF_CNT_EN
        , .perf_issue_cnt(a_perf_issue), .perf_stall_cnt(a_perf_stall)
`endif
    );

    nios_mul_share_arbiter #(.NUM_REQ(3), .LATENCY(3)) u_b (
        .clk(clk), .reset(b_reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_src1(b_src1), .req_src2(b_src2),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_result(b_rsp_result),
        .mul_src1(b_mul_src1), .mul_src2(b_mul_src2), .mul_result(b_mul_result),
        .busy(b_busy)
`ifdef MUL_SHARE_PERF_CNT_EN
        , .perf_issue_cnt(b_perf_issue), .perf_stall_cnt(b_perf_stall)
`endif
    );

    // Behavioural multiplier cells with 1 and 3 register stages.
    always @(posedge clk) a_mul_result <= a_mul_src1 * a_mul_src2;
    always @(posedge clk) begin
        b_p1         <= b_mul_src1 * b_mul_src2;
        b_p2         <= b_p1;
        b_mul_result <= b_p2;
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Pushed in the accepting cycle; the response rises LATENCY edges after the accepting edge.
    task automatic expa(input int id, input logic [31:0] v);
        qa.push_back('{id: 3'(id), val: v, due: cyc + 32'd2});
    endtask

    task automatic expb(input int id, input logic [31:0] v);
        qb.push_back('{id: 3'(id), val: v, due: cyc + 32'd4});
    endtask

    // Scoreboard monitors: compare id, value and arrival cycle on each rsp_valid rise.
    initial begin
        logic [1:0] prev;
        exp_t       e;
        prev = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (a_rsp_valid[i] && !prev[i]) begin
                    if (qa.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL a_unexpected_rsp: requester %0d got %h, expected no response", i, a_rsp_result[i*32 +: 32]);
                    end else begin
                        e = qa.pop_front();
                        check("a_rsp {id,val,cyc}", 96'({3'(i), a_rsp_result[i*32 +: 32], cyc}), 96'(e));
                    end
                end
            end
            prev = a_rsp_valid;
        end
    end

    initial begin
        logic [2:0] prev;
        exp_t       e;
        prev = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (b_rsp_valid[i] && !prev[i]) begin
                    if (qb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL b_unexpected_rsp: requester %0d got %h, expected no response", i, b_rsp_result[i*32 +: 32]);
                    end else begin
                        e = qb.pop_front();
                        check("b_rsp {id,val,cyc}", 96'({3'(i), b_rsp_result[i*32 +: 32], cyc}), 96'(e));
                    end
                end
            end
            prev = b_rsp_valid;
        end
    end

    initial begin
        logic [1:0] ctn[6];
        logic [1:0] bp[12];
        logic [2:0] rot[8];
        ctn = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
        bp  = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        rot = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100};

        a_reset = 1'b1; a_req_valid = 2'b11; a_rsp_ready = '0;
        a_src1 = {32'd5, 32'd9}; a_src2 = {32'd4, 32'd3};
        b_reset = 1'b1; b_req_valid = '0; b_rsp_ready = '0; b_src1 = '0; b_src2 = '0;

        // Reset state, requests asserted during reset must not be granted
        repeat (2) neg();
        check("a_reset_req_ready", 96'(a_req_ready), 96'(0));
        check("a_reset_rsp_valid", 96'(a_rsp_valid), 96'(0));
        check("a_reset_rsp_result", 96'(a_rsp_result), 96'(0));
        check("a_reset_busy", 96'(a_busy), 96'(0));
        check("a_reset_mul_src", 96'({a_mul_src1, a_mul_src2}), 96'(0));
`ifdef MUL_SHARE_PERF_CNT_EN
        check("a_reset_perf", 96'({a_perf_issue, a_perf_stall}), 96'(0));
`endif
        step();
        a_reset = 1'b0; a_req_valid = '0;

        // Single requester: 7*6
        a_src1[31:0] = 32'd7; a_src2[31:0] = 32'd6; a_req_valid = 2'b01;
        expa(0, 32'd42);
        neg();
        check("t1_grant", 96'(a_req_ready), 96'(2'b01));
        check("t1_mul_src", 96'({a_mul_src1, a_mul_src2}), 96'({32'd7, 32'd6}));
        step();
        a_req_valid = '0;
        neg();
        check("t1_busy_inflight", 96'(a_busy), 96'(1));
        check("t1_no_rsp_yet", 96'(a_rsp_valid), 96'(0));
        step();
        // Hold without ack while requester 0 re-requests: no grant while pending
        a_src1[31:0] = 32'h0001_0000; a_src2[31:0] = 32'h0001_0001; a_req_valid = 2'b01;
        for (int h = 0; h < 3; h++) begin
            neg();
            check("t1_hold_no_grant", 96'(a_req_ready), 96'(0));
            check("t1_hold_rsp", 96'({a_rsp_valid, a_rsp_result[31:0]}), 96'({2'b01, 32'd42}));
            check("t1_hold_busy", 96'(a_busy), 96'(0));
            step();
        end
        a_rsp_ready = 2'b01;
        neg();
        check("t1_same_cycle_hs_no_grant", 96'(a_req_ready), 96'(0));
        step();
        expa(0, 32'h0001_0000);
        neg();
        check("t1_reissue_grant", 96'(a_req_ready), 96'(2'b01));
        check("t1_rsp_cleared", 96'(a_rsp_valid), 96'(0));
        step();
        a_req_valid = '0;
        repeat (3) step();

        // Contention from reset, responses always acked
        a_reset = 1'b1; a_rsp_ready = 2'b11;
        step();
        neg();
`ifdef MUL_SHARE_PERF_CNT_EN
        check("perf_cleared_by_reset", 96'({a_perf_issue, a_perf_stall}), 96'(0));
`endif
        check("ctn_reset_busy", 96'(a_busy), 96'(0));
        step();
        a_reset = 1'b0;
        a_src1 = {32'h0001_0000, 32'hFFFF_FFFF}; a_src2 = {32'h0001_0001, 32'd2};
        a_req_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            if (ctn[c][0]) expa(0, 32'hFFFF_FFFE);
            if (ctn[c][1]) expa(1, 32'h0001_0000);
            neg();
            check("ctn_grant", 96'(a_req_ready), 96'(ctn[c]));
            step();
        end
        a_req_valid = '0;
`ifdef MUL_SHARE_PERF_CNT_EN
        neg();
        check("ctn_perf {issue,stall}", 96'({a_perf_issue, a_perf_stall}), 96'({32'd4, 32'd1}));
`endif
        repeat (3) step();

        // Backpressure: requester 1 result not acked for 12 cycles
        a_rsp_ready = 2'b01;
        a_src1 = {32'h0000_1234, 32'h8000_0001}; a_src2 = {32'h0000_0010, 32'd3};
        a_req_valid = 2'b11;
        for (int c = 0; c < 12; c++) begin
            if (bp[c][0]) expa(0, 32'h8000_0003);
            if (bp[c][1]) expa(1, 32'h0001_2340);
            neg();
            check("bp_grant", 96'(a_req_ready), 96'(bp[c]));
            if (c >= 3) check("bp_hold_req1", 96'({a_rsp_valid[1], a_rsp_result[63:32]}), 96'({1'b1, 32'h0001_2340}));
            step();
        end
        a_req_valid = '0; a_rsp_ready = 2'b11;
`ifdef MUL_SHARE_PERF_CNT_EN
        neg();
        check("bp_perf {issue,stall}", 96'({a_perf_issue, a_perf_stall}), 96'({32'd9, 32'd2}));
`endif
        repeat (3) step();
        check("a_queue_drained", 96'(qa.size()), 96'(0));

        // DUT B: 3-way rotation at latency 3
        b_reset = 1'b0; b_rsp_ready = 3'b111;
        b_src1 = {32'h1234_5678, 32'hFFFF_FFFF, 32'd3};
        b_src2 = {32'h0000_0010, 32'hFFFF_FFFF, 32'd5};
        b_req_valid = 3'b111;
        for (int c = 0; c < 8; c++) begin
            if (rot[c][0]) expb(0, 32'd15);
            if (rot[c][1]) expb(1, 32'd1);
            if (rot[c][2]) expb(2, 32'h2345_6780);
            neg();
            check("b_rot_grant", 96'(b_req_ready), 96'(rot[c]));
            if (c == 3) check("b_idle_mul_src_zero", 96'({b_mul_src1, b_mul_src2}), 96'(0));
            step();
        end
        b_req_valid = '0;
        repeat (6) step();

        // Reset one cycle after an accept: nothing may come out, arbitration restarts at 0
        b_reset = 1'b1;
        step();
        b_reset = 1'b0; b_req_valid = 3'b010;
        neg();
        check("b_pre_reset_grant", 96'(b_req_ready), 96'(3'b010));
        step();
        b_req_valid = '0;
        neg();
        check("b_inflight_busy", 96'(b_busy), 96'(1));
        step();
        b_reset = 1'b1; b_req_valid = 3'b111;
        qb.delete();
        neg();
        check("b_reset_busy", 96'(b_busy), 96'(0));
        check("b_reset_no_grant", 96'(b_req_ready), 96'(0));
        step();
        b_reset = 1'b0; b_req_valid = '0;
        repeat (5) step();
        neg();
        check("b_post_reset_quiet {busy,rsp_valid}", 96'({b_busy, b_rsp_valid}), 96'(0));
        step();
        b_req_valid = 3'b111;
        expb(0, 32'd15);
        neg();
        check("b_post_reset_first_grant", 96'(b_req_ready), 96'(3'b001));
        step();
        b_req_valid = '0;
        repeat (6) step();
        check("b_queue_drained", 96'(qb.size()), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
